// File: rtl/sort_feeder.sv
// Feeds eight-byte frames into an external sorter, starts the sort, waits for completion
// with a timeout, then streams the sorted bytes out under a valid/ready handshake.
module sort_feeder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       s_wr,
  output logic       s_start,
  output logic [2:0] s_addr,
  output logic [7:0] s_datain,
  input  logic [7:0] s_dataout,
  input  logic       s_ready,
  output logic       busy,
  output logic       err
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT_LO,
    WAIT_HI,
    RD_REQ,
    RD_CAP,
    OUT
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    k_q, k_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  // This wait cycle is the TIMEOUT-th one since START cleared the counter.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      k_q         <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    s_wr        = 1'b0;
    s_start     = 1'b0;
    s_addr      = k_q;
    s_datain    = in_data;

    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        s_wr     = in_valid;
        s_addr   = cnt_q;
        if (in_valid) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = START;
        end
      end
      START: begin
        s_start = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO, WAIT_HI: begin
        tmo_d = tmo_q + 1'b1;
        if (state_q == WAIT_LO && !s_ready) begin
          state_d = WAIT_HI;
        end else if (state_q == WAIT_HI && s_ready) begin
          state_d = RD_REQ;
          k_d     = '0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      RD_REQ: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        out_data_d  = s_dataout;
        out_last_d  = (k_q == 3'd7);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (k_q == 3'd7) begin
            k_d     = '0;
            state_d = LOAD;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign busy      = (state_q != LOAD);

endmodule

// File: tb/tb_sort_feeder.sv
// Scoreboard bench for sort_feeder with a behavioural sorter attached to the sorter port.
module tb_sort_feeder;

  typedef logic [7:0] frame_t [8];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       s_wr, s_start;
  logic [2:0] s_addr;
  logic [7:0] s_datain;
  logic [7:0] s_dataout = '0;
  logic       s_ready = 1'b1;
  logic       busy, err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_hs = -100;
  int start_cnt = 0;
  logic [8:0] exp_q [$];
  logic [2:0] wr_addrs [$];

  // Sorter model state
  logic [7:0] mem [8];
  int  scnt = 0;
  bit  stuck = 1'b0;

  sort_feeder #(.TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .s_wr(s_wr), .s_start(s_start), .s_addr(s_addr), .s_datain(s_datain),
    .s_dataout(s_dataout), .s_ready(s_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic frame_t sorted(input frame_t f);
    frame_t t = f;
    logic [7:0] x;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (t[j] > t[j+1]) begin
          x = t[j]; t[j] = t[j+1]; t[j+1] = x;
        end
    return t;
  endfunction

  // Sorter: drops s_ready after start, sorts memory a few cycles later, reads are registered.
  always @(posedge clk) begin
    frame_t tmp;
    if (s_wr) mem[s_addr] <= s_datain;
    if (s_start) begin
      s_ready <= 1'b0;
      scnt    <= 5;
    end else if (!s_ready && !stuck) begin
      if (scnt == 0) begin
        tmp = sorted(mem);
        for (int i = 0; i < 8; i++) mem[i] <= tmp[i];
        s_ready <= 1'b1;
      end else begin
        scnt <= scnt - 1;
      end
    end
    s_dataout <= mem[s_addr];
  end

  // Monitor: inputs only change #1 after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_start_excl", {31'd0, s_wr & s_start}, 32'd0);
      if (busy) chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (s_wr) wr_addrs.push_back(s_addr);
      if (s_start) start_cnt++;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("out_byte", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
        if (last_hs >= 0) chk("out_gap_ge3", {31'd0, (cyc - last_hs) >= 3}, 32'd1);
        last_hs = cyc;
      end
    end
  end

  task automatic load_frame(input frame_t f, input bit push, input bit hold);
    frame_t s = sorted(f);
    if (push)
      for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, s[i]});
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = f[i];
      @(posedge clk); #1;
    end
    if (!hold) in_valid = 1'b0;
    else in_data = 8'hEE;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("drain_timeout", {31'd0, n < budget}, 32'd1);
    last_hs = -100;
  endtask

  initial begin
    frame_t f;
    int s0, n;
    logic [8:0] held;

    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out", {22'd0, out_valid, out_last, out_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame with ready always high
    f = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
    s0 = start_cnt;
    wr_addrs.delete();
    load_frame(f, 1'b1, 1'b0);
    wait_idle(300);
    chk("start_pulses", start_cnt - s0, 32'd1);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
    chk("err_clean", {31'd0, err}, 32'd0);

    // Output stall for 10 cycles
    f = '{8'h90, 8'h10, 8'h80, 8'h20, 8'h70, 8'h30, 8'h60, 8'h40};
    out_ready = 1'b0;
    load_frame(f, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("stall_valid_seen", {31'd0, out_valid}, 32'd1);
    held = {out_last, out_data};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {23'd0, out_last, out_data}, {23'd0, held});
    end
    out_ready = 1'b1;
    wait_idle(300);

    // in_valid held high through the whole frame
    f = '{8'h33, 8'h11, 8'h77, 8'h55, 8'h22, 8'h66, 8'h44, 8'h00};
    wr_addrs.delete();
    load_frame(f, 1'b1, 1'b1);
    wait_idle(300);
    chk("wr_count", wr_addrs.size(), 32'd8);
    for (int i = 0; i < 8 && i < wr_addrs.size(); i++) chk("wr_addr", {29'd0, wr_addrs[i]}, i);

    // Two back-to-back all-0xFF frames
    f = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    load_frame(f, 1'b1, 1'b0);
    wait_idle(300);
    load_frame(f, 1'b1, 1'b0);
    wait_idle(300);

    // Sorter never completes: timeout after 20 wait cycles
    stuck = 1'b1;
    f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_frame(f, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1 chk("err_before_timeout", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    chk("err_at_timeout", {31'd0, err}, 32'd1);
    chk("load_after_timeout", {31'd0, busy}, 32'd0);
    stuck = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Normal operation resumes, err stays set
    f = '{8'hC8, 8'h01, 8'h7F, 8'h80, 8'h02, 8'hFE, 8'h40, 8'h3C};
    load_frame(f, 1'b1, 1'b0);
    wait_idle(300);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset after 4 beats, then a full frame
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h50 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_err_clear", {31'd0, err}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    f = '{8'd8, 8'd8, 8'd1, 8'd1, 8'd9, 8'd9, 8'd2, 8'd2};
    wr_addrs.delete();
    load_frame(f, 1'b1, 1'b0);
    wait_idle(300);
    chk("rst_frame_wr_count", wr_addrs.size(), 32'd8);
    if (wr_addrs.size() > 0) chk("rst_frame_first_addr", {29'd0, wr_addrs[0]}, 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sort_feeder.md
SORT_FEEDER -- requirements
Module: sort_feeder

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the max cycles spent waiting for sorter completion before abort.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 in_valid  in  1  upstream byte valid.
REQ-006 in_data  in  8  upstream byte.
REQ-007 in_ready  out  1  block accepts a byte this cycle.
REQ-008 out_valid  out  1  sorted byte valid.
REQ-009 out_data  out  8  sorted byte.
REQ-010 out_last  out  1  marks the 8th sorted byte.
REQ-011 out_ready  in  1  downstream accepts the byte.
REQ-012 s_wr, s_start  out  1 each  sorter write strobe and start pulse.
REQ-013 s_addr  out  3  sorter address.
REQ-014 s_datain  out  8  sorter write data.
REQ-015 s_dataout  in  8  sorter read data, one cycle after the address is presented while the sorter is idle and s_wr=0.
REQ-016 s_ready  in  1  sorter idle flag.
REQ-017 busy  out  1  high in every state except LOAD.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 The block SHALL be a state machine with states LOAD, START, WAIT_LO, WAIT_HI, RD_REQ, RD_CAP, OUT.
REQ-020 LOAD: in_ready=1 and s_wr=in_valid; s_addr=cnt; s_datain=in_data; on each accepted beat cnt increments; on the 8th beat (cnt=7) cnt wraps to 0 and the state goes to START.
REQ-021 in_ready, s_wr and s_start SHALL be 0 in every state other than the one that drives them; s_wr and s_start SHALL never be high together.
REQ-022 START: s_start=1 for exactly one cycle, s_wr=0; the state goes to WAIT_LO and the timeout counter clears.
REQ-023 WAIT_LO: wait for s_ready=0, then go to WAIT_HI; WAIT_HI: wait for s_ready=1, then go to RD_REQ with k=0.
REQ-024 In WAIT_LO and WAIT_HI the timeout counter increments each cycle; reaching TIMEOUT SHALL set err=1, clear cnt and return to LOAD; no output beat is produced.
REQ-025 RD_REQ: s_addr=k, s_wr=0, lasting one cycle, then RD_CAP.
REQ-026 RD_CAP: s_addr=k held; s_dataout is registered into out_data, out_last is loaded with (k==7), and out_valid becomes 1 on the next edge; then OUT.
REQ-027 OUT: out_valid, out_data and out_last SHALL be held stable until out_ready=1; on handshake out_valid drops; if k=7 the state goes to LOAD, else k+1 and RD_REQ.
REQ-028 Output throughput SHALL be at most one byte per 3 cycles; bytes leave in ascending address order, i.e. sorted ascending.
REQ-029 An in_valid asserted outside LOAD SHALL be ignored with in_ready=0, and no sorter write is issued.
REQ-030 err SHALL clear only on rst; operation continues normally after a timeout.

Reset
REQ-031 rst SHALL force LOAD, cnt=0, k=0, timeout counter=0, out_valid=0, out_data=0, out_last=0, err=0 immediately and independent of clk.
REQ-032 Reset mid-frame SHALL discard the partial frame; sorter memory contents are not cleared; the next frame SHALL overwrite all 8 entries.

Verification
REQ-033 Load 5,3,7,1,0,6,2,4 with out_ready=1 -> s_start pulses once, then out_data 0..7 in order, out_last only on byte 7, busy drops after it.
REQ-034 Load a frame, hold out_ready=0 for 10 cycles in OUT -> out_data/out_valid stable; release -> no byte lost or duplicated.
REQ-035 Keep in_valid=1 continuously through one frame -> exactly 8 writes with s_addr 0..7, in_ready=0 from START until the last byte is output.
REQ-036 Sorter model that never raises s_ready again, TIMEOUT=20 -> err=1 after 20 wait cycles, back in LOAD, no out_valid.
REQ-037 Assert rst after the 4th input beat, then load 8,8,1,1,9,9,2,2 -> output 1,1,2,2,8,8,9,9 with no residue from the aborted frame.
REQ-038 Two back-to-back frames of all-equal values (0xFF) -> 16 bytes 0xFF output, out_last on the 8th and 16th.
